// File: rtl/sw_debounce.sv
// Switch debouncer: 2-flop synchronizer plus a slowref-gated FSM that emits one press pulse per press.
// Optional release pulse enabled by defining SW_DEBOUNCE_REL_PULSE_EN.
//   state     | meaning
//   IDLE      | switch accepted as released
//   PRESS_CHK | counting consecutive pressed samples
//   HELD      | switch accepted as pressed
//   REL_CHK   | counting consecutive released samples
module sw_debounce #(
  parameter int DB_COUNT = 4
) (
  input  logic clk,
  input  logic resetb,
  input  logic slowref,
  input  logic sw_raw,
  output logic sw_level,
  output logic sw_pulse
`ifdef SW_DEBOUNCE_REL_PULSE_EN
  ,
  output logic sw_rel_pulse
`endif
);

  localparam int CW = $clog2(DB_COUNT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          at_limit;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic          sw_sync;
`ifdef SW_DEBOUNCE_REL_PULSE_EN
  logic          rel_q, rel_d;
`endif

  assign sw_sync  = sync2_q;
  assign cnt_inc  = cnt_q + CW'(1);
  assign at_limit = (cnt_inc == CW'(DB_COUNT));

  always_comb begin
    sync1_d = sw_raw;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = pulse_q;
`ifdef SW_DEBOUNCE_REL_PULSE_EN
    rel_d   = rel_q;
`endif
    if (slowref) begin
      // Event pulses last exactly one slowref period.
      pulse_d = 1'b0;
`ifdef SW_DEBOUNCE_REL_PULSE_EN
      rel_d   = 1'b0;
`endif
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (sw_sync) begin
            state_d = PRESS_CHK;
            cnt_d   = CW'(1);
          end
        end
        PRESS_CHK: begin
          if (!sw_sync) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (at_limit) begin
            state_d = HELD;
            cnt_d   = '0;
            level_d = 1'b1;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HELD: begin
          cnt_d = '0;
          if (!sw_sync) begin
            state_d = REL_CHK;
            cnt_d   = CW'(1);
          end
        end
        REL_CHK: begin
          if (sw_sync) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (at_limit) begin
            state_d = IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
`ifdef SW_DEBOUNCE_REL_PULSE_EN
            rel_d   = 1'b1;
`endif
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

`ifdef SW_DEBOUNCE_REL_PULSE_EN
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) rel_q <= 1'b0;
    else         rel_q <= rel_d;
  end

  assign sw_rel_pulse = rel_q;
`endif

  assign sw_level = level_q;
  assign sw_pulse = pulse_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Testbench for sw_debounce (DB_COUNT = 4, slowref every 8 clk): table rows, reset corner cases,
// slowref-off check and randomized stimulus against a consecutive-disagreement reference model.
module tb_sw_debounce;

  localparam int DB  = 4;
  localparam int PER = 8;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  logic slowref = 1'b0;
  logic sw_raw = 1'b0;
  logic sw_level, sw_pulse;
`ifdef SW_DEBOUNCE_REL_PULSE_EN
  logic sw_rel_pulse;
`endif

  always #5 clk = ~clk;

  sw_debounce #(.DB_COUNT(DB)) dut (
    .clk      (clk),
    .resetb   (resetb),
    .slowref  (slowref),
    .sw_raw   (sw_raw),
    .sw_level (sw_level),
`ifdef SW_DEBOUNCE_REL_PULSE_EN
    .sw_rel_pulse (sw_rel_pulse),
`endif
    .sw_pulse (sw_pulse)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int sr_mode = 0;
  int tick_cnt = 0;
  int rise_tick = -1;
  int press_rises = 0;
  int rel_rises = 0;
  int pulse_hi = 0;
  logic prev_p = 1'b0;
  logic prev_r = 1'b0;

  // Reference: accepted level flips after DB consecutive samples that disagree with it.
  logic m_s1, m_s2, m_level, m_pulse, m_rel;
  int   m_run;

  typedef struct {
    logic raw;
    int   ticks;
    logic exp_level;
    int   exp_press;
    int   exp_rel;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_pulse = 1'b0; m_rel = 1'b0; m_run = 0;
  endtask

  task automatic model_edge(input logic raw, input logic tick);
    logic s;
    s    = m_s2;
    m_s2 = m_s1;
    m_s1 = raw;
    if (tick) begin
      m_pulse = 1'b0;
      m_rel   = 1'b0;
      if (s != m_level) begin
        m_run++;
        if (m_run == DB) begin
          m_level = s;
          m_run   = 0;
          if (s) m_pulse = 1'b1;
          else   m_rel   = 1'b1;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_level"}, sw_level, m_level);
    check({tag, "_pulse"}, sw_pulse, m_pulse);
`ifdef SW_DEBOUNCE_REL_PULSE_EN
    check({tag, "_rel_pulse"}, sw_rel_pulse, m_rel);
`endif
  endtask

  task automatic cycle();
    @(negedge clk);
    case (sr_mode)
      0:       slowref = (cyc % PER == PER - 1);
      1:       slowref = ($urandom_range(3) == 0);
      default: slowref = 1'b0;
    endcase
    @(posedge clk);
    cyc++;
    if (resetb) begin
      model_edge(sw_raw, slowref);
      if (slowref) tick_cnt++;
    end else begin
      model_clear();
    end
    #1;
    check_outputs("cyc");
    if (sw_pulse && !prev_p) begin
      press_rises++;
      rise_tick = tick_cnt;
    end
    if (sw_pulse) pulse_hi++;
    prev_p = sw_pulse;
`ifdef SW_DEBOUNCE_REL_PULSE_EN
    if (sw_rel_pulse && !prev_r) rel_rises++;
    prev_r = sw_rel_pulse;
`endif
  endtask

  task automatic hold(input logic raw, input int n);
    sw_raw = raw;
    repeat (n) cycle();
  endtask

  task automatic align();
    while (cyc % PER != 0) cycle();
  endtask

  task automatic assert_reset(input string tag);
    resetb = 1'b0;
    #1;
    model_clear();
    check({tag, "_level"}, sw_level, 1'b0);
    check({tag, "_pulse"}, sw_pulse, 1'b0);
`ifdef SW_DEBOUNCE_REL_PULSE_EN
    check({tag, "_rel_pulse"}, sw_rel_pulse, 1'b0);
`endif
  endtask

  // Releases reset just after a tick, then measures press latency and pulse width with sw_raw held high.
  task automatic release_and_measure(input string tag);
    repeat (2) cycle();
    align();
    resetb    = 1'b1;
    tick_cnt  = 0;
    rise_tick = -1;
    pulse_hi  = 0;
    hold(1'b1, 6 * PER);
    check_int({tag, "_latency_ticks"}, rise_tick, DB);
    check_int({tag, "_pulse_width"}, pulse_hi, PER);
    check({tag, "_level_after"}, sw_level, 1'b1);
  endtask

  initial begin
    model_clear();
    tbl.push_back('{1'b1, 12, 1'b1, 1, 0});
    tbl.push_back('{1'b0,  2, 1'b1, 0, 0});
    tbl.push_back('{1'b1,  3, 1'b1, 0, 0});
    tbl.push_back('{1'b0,  3, 1'b1, 0, 0});
    tbl.push_back('{1'b1,  1, 1'b1, 0, 0});
    tbl.push_back('{1'b0,  5, 1'b0, 0, 1});
    for (int i = 0; i < 10; i++) tbl.push_back('{(i % 2 == 0), 1, 1'b0, 0, 0});
    tbl.push_back('{1'b0,  2, 1'b0, 0, 0});
    tbl.push_back('{1'b1,  3, 1'b0, 0, 0});
    tbl.push_back('{1'b0,  1, 1'b0, 0, 0});
    tbl.push_back('{1'b1,  4, 1'b1, 1, 0});
    tbl.push_back('{1'b1, 62, 1'b1, 0, 0});
    tbl.push_back('{1'b0,  4, 1'b0, 0, 1});

    repeat (3) cycle();
    check("reset_level", sw_level, 1'b0);
    check("reset_pulse", sw_pulse, 1'b0);
    align();
    resetb = 1'b1;

    foreach (tbl[i]) begin
      press_rises = 0;
      rel_rises   = 0;
      hold(tbl[i].raw, tbl[i].ticks * PER);
      check("row_level", sw_level, tbl[i].exp_level);
      check_int("row_press_pulses", press_rises, tbl[i].exp_press);
`ifdef SW_DEBOUNCE_REL_PULSE_EN
      check_int("row_rel_pulses", rel_rises, tbl[i].exp_rel);
`endif
    end

    // Reset while three pressed samples are pending.
    hold(1'b1, 3 * PER);
    assert_reset("rst_mid_chk");
    release_and_measure("rst_mid_chk");

    // Reset while the press pulse is high.
    hold(1'b0, 5 * PER);
    check("pre_press_level", sw_level, 1'b0);
    hold(1'b1, 4 * PER);
    hold(1'b1, 3);
    check("mid_pulse_high", sw_pulse, 1'b1);
    assert_reset("rst_mid_pulse");
    release_and_measure("rst_mid_pulse");

    // slowref held low: nothing may move.
    sr_mode = 2;
    press_rises = 0;
    for (int i = 0; i < 200; i++) begin
      if (i % 3 == 0) sw_raw = ~sw_raw;
      cycle();
    end
    check("sr_off_level", sw_level, 1'b1);
    check_int("sr_off_pulses", press_rises, 0);

    // Randomized phase with irregular ticks and occasional resets.
    sr_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(9) == 0) sw_raw = ~sw_raw;
      if ($urandom_range(1499) == 0) begin
        assert_reset("rand_rst");
        cycle();
        resetb = 1'b1;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
